// File: rtl/sevseg_scan_n_if.sv
// Bundle of snapshot inputs and display drive outputs for sevseg_scan_n.
// master: digits/blank/dp/brightness out, seg/dp_n/an/frame_start in; slave opposite.
interface sevseg_scan_n_if #(
  parameter int NDIG = 4
);
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   blank;
  logic [NDIG-1:0]   dp;
  logic [3:0]        brightness;
  logic [6:0]        seg;
  logic              dp_n;
  logic [NDIG-1:0]   an;
  logic              frame_start;

  modport master (
    output digits, blank, dp, brightness,
    input  seg, dp_n, an, frame_start
  );

  modport slave (
    input  digits, blank, dp, brightness,
    output seg, dp_n, an, frame_start
  );
endinterface

// File: rtl/sevseg_scan_n.sv
// Multiplexed common-anode 7-segment scanner with frame snapshot and PWM.
// Ports: clk, reset (sync, active-high), bus (slave). Option: SEVSEG_LZS_EN.
module sevseg_scan_n #(
  parameter int NDIG    = 4,
  parameter int DIVBITS = 18
) (
  input logic        clk,
  input logic        reset,
  sevseg_scan_n_if.slave bus
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  logic [DIVBITS-1:0] div;
  logic [IW-1:0]      idx;
  logic               wrap;
  logic               load;

  logic [3:0]      sh_dig [NDIG];
  logic [NDIG-1:0] sh_blank;
  logic [NDIG-1:0] sh_dp;
  logic [3:0]      sh_bright;

  logic [NDIG-1:0] dark;
  logic [3:0]      phase;
  logic            lit;

  logic [NDIG-1:0] an_d;
  logic [6:0]      seg_d;
  logic            dpn_d;

  assign wrap  = &div;
  assign load  = wrap && (idx == LAST);
  assign phase = div[DIVBITS-1 -: 4];

  function automatic logic [6:0] dec(
    input logic [3:0] nib
  );
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= div + DIVBITS'(1);
      if (wrap) begin
        idx <= (idx == LAST) ? '0 : idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) begin
        sh_dig[i] <= '0;
      end
      sh_blank  <= '1;
      sh_dp     <= '0;
      sh_bright <= '0;
    end else if (load) begin
      for (int i = 0; i < NDIG; i++) begin
        sh_dig[i] <= bus.digits[4*i +: 4];
      end
      sh_blank  <= bus.blank;
      sh_dp     <= bus.dp;
      sh_bright <= bus.brightness;
    end
  end

`ifdef SEVSEG_LZS_EN
  // A digit is a leading zero when it and every digit above it
  // are zero with no decimal point; digit 0 always shows.
  logic [NDIG-1:0] sup;

  always_comb begin
    logic zrun;
    sup  = '0;
    zrun = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      zrun   = zrun & (sh_dig[i] == 4'h0) & ~sh_dp[i];
      sup[i] = zrun;
    end
  end

  assign dark = sh_blank | sup;
`else
  assign dark = sh_blank;
`endif

  assign lit = (phase <= sh_bright) && !dark[idx];

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if (lit) begin
      an_d[idx] = 1'b0;
      seg_d     = dec(sh_dig[idx]);
      dpn_d     = ~sh_dp[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.an          <= '1;
      bus.seg         <= 7'h7F;
      bus.dp_n        <= 1'b1;
      bus.frame_start <= 1'b0;
    end else begin
      bus.an          <= an_d;
      bus.seg         <= seg_d;
      bus.dp_n        <= dpn_d;
      bus.frame_start <= load;
    end
  end

endmodule
